noise_lfsr_gen: RTL and testbench

NOISE_LFSR_GEN -- requirements
Module: noise_lfsr_gen

---
 rtl/noise_lfsr_gen.sv | 63 ++++++
 tb/tb_noise_lfsr_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/noise_lfsr_gen.sv
// Rate-divided Galois-free Fibonacci LFSR noise source with long/short tap modes,
// seed loading, lock-up guard and a registered amplitude-gated sample output.
module noise_lfsr_gen #(
  parameter int unsigned LFSR_WIDTH = 15,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned SEED       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [DIV_WIDTH-1:0]  period,
  input  logic [OUT_WIDTH-1:0]  amplitude,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [OUT_WIDTH-1:0]  noise_out,
  output logic                  step
);

  // An all-zero seed would lock the register, so zero always maps to one.
  localparam logic [LFSR_WIDTH-1:0] SEED_TRUNC = LFSR_WIDTH'(SEED);
  localparam logic [LFSR_WIDTH-1:0] SEED_INIT  =
    (SEED_TRUNC == '0) ? LFSR_WIDTH'(1) : SEED_TRUNC;

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic                  fb;
  logic                  step_event;

  assign fb         = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);
  assign step_event = enable && (div_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= SEED_INIT;
      div_cnt   <= '0;
      noise_out <= '0;
      step      <= 1'b0;
    end else begin
      noise_out <= lfsr[0] ? amplitude : '0;
      step      <= 1'b0;
      if (seed_load) begin
        lfsr    <= (seed == '0) ? LFSR_WIDTH'(1) : seed;
        div_cnt <= period;
      end else begin
        // The lock-up guard overrides any shift and does not wait for enable.
        if (lfsr == '0) begin
          lfsr <= LFSR_WIDTH'(1);
        end else if (step_event) begin
          lfsr <= {fb, lfsr[LFSR_WIDTH-1:1]};
        end
        if (step_event) begin
          div_cnt <= period;
          step    <= 1'b1;
        end else if (enable) begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noise_lfsr_gen.sv
// Scoreboard bench for noise_lfsr_gen: directed segments with hand-computed
// expectations, a step-triggered monitor, and cycle-length checks of both modes.
module tb_noise_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [15:0] period;
  logic [7:0]  amplitude;
  logic        seed_load;
  logic [14:0] seed;
  logic [7:0]  noise_out;
  logic        step;

  typedef struct packed {
    logic [14:0] lfsr;
    logic [7:0]  noise;
  } exp_t;

  exp_t sbq[$];
  bit   mon_on = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  noise_lfsr_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
    .amplitude(amplitude), .seed_load(seed_load), .seed(seed),
    .noise_out(noise_out), .step(step)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic md, input logic [15:0] per,
                               input logic [7:0] amp);
    enable    = en;
    mode      = md;
    period    = per;
    amplitude = amp;
  endtask

  task automatic pushExp(input logic [14:0] l, input logic [7:0] n);
    exp_t e;
    e.lfsr  = l;
    e.noise = n;
    sbq.push_back(e);
  endtask

  task automatic waitStep(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < maxc);
  endtask

  // Monitor: every step pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on && step) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_step", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("sb_lfsr", 32'(dut.lfsr), 32'(e.lfsr));
          checkOutput("sb_noise", 32'(noise_out), 32'(e.noise));
        end
      end
    end
  end

  initial begin
    int n;
    int cnt;
    reset     = 1'b1;
    seed_load = 1'b0;
    seed      = '0;
    applyStimulus(1'b0, 1'b0, 16'd0, 8'h00);

    #12;
    checkOutput("rst_lfsr", 32'(dut.lfsr), 32'h1);
    checkOutput("rst_div", 32'(dut.div_cnt), 32'h0);
    checkOutput("rst_noise", 32'(noise_out), 32'h0);
    checkOutput("rst_step", 32'(step), 32'h0);

    // First enabled edge after reset steps immediately; period 0 steps every cycle.
    @(negedge clk);
    pushExp(15'h4000, 8'hA5);
    pushExp(15'h2000, 8'h00);
    pushExp(15'h1000, 8'h00);
    pushExp(15'h0800, 8'h00);
    mon_on = 1'b1;
    reset  = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'd0, 8'hA5);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    mon_on = 1'b0;

    // Divider spacing, then stretched by a five-cycle enable gap.
    applyStimulus(1'b1, 1'b0, 16'd3, 8'hA5);
    waitStep(20, n);
    waitStep(20, n);
    checkOutput("div_gap", 32'(n), 32'd4);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    waitStep(20, n);
    checkOutput("div_gap_stretched", 32'(n + 5), 32'd9);

    // Seed load of zero coincident with a step event.
    repeat (3) @(negedge clk);
    checkOutput("pre_load_div", 32'(dut.div_cnt), 32'd0);
    seed_load = 1'b1;
    seed      = 15'h0;
    period    = 16'd7;
    @(negedge clk);
    seed_load = 1'b0;
    enable    = 1'b0;
    checkOutput("load_lfsr", 32'(dut.lfsr), 32'h1);
    checkOutput("load_step", 32'(step), 32'h0);
    checkOutput("load_div", 32'(dut.div_cnt), 32'd7);

    // Lock-up guard works while disabled.
    force dut.lfsr = 15'h0;
    #1 release dut.lfsr;
    @(negedge clk);
    checkOutput("lockup_recover", 32'(dut.lfsr), 32'h1);

    // Output tracks amplitude with one cycle latency, even while disabled.
    amplitude = 8'hA5;
    @(negedge clk);
    checkOutput("noise_a5", 32'(noise_out), 32'hA5);
    amplitude = 8'h3C;
    @(negedge clk);
    checkOutput("noise_3c_disabled", 32'(noise_out), 32'h3C);

    // Full cycle lengths of both tap modes, starting from 1.
    applyStimulus(1'b1, 1'b0, 16'd0, 8'h3C);
    cnt = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (step) cnt++;
      if (cnt > 0 && dut.lfsr == 15'h1) break;
    end
    enable = 1'b0;
    checkOutput("long_period", 32'(cnt), 32'd32767);

    applyStimulus(1'b1, 1'b1, 16'd0, 8'h3C);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (step) cnt++;
      if (cnt > 0 && dut.lfsr == 15'h1) break;
    end
    enable = 1'b0;
    checkOutput("short_period", 32'(cnt), 32'd93);

    // Asynchronous reset in the middle of a count.
    applyStimulus(1'b1, 1'b0, 16'd10, 8'hFF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_lfsr", 32'(dut.lfsr), 32'h1);
    checkOutput("async_rst_div", 32'(dut.div_cnt), 32'h0);
    checkOutput("async_rst_noise", 32'(noise_out), 32'h0);
    checkOutput("async_rst_step", 32'(step), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
